instr_mem_responder: RTL and testbench

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/instr_mem_responder.sv | 114 +++++++++++
 tb/tb_instr_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction store with a pipelined, in-order fetch responder.
// Two register stages feed a response FIFO; occupancy-based flow control.
module instr_mem_responder #(
    parameter int DBITS      = 32,
    parameter int IMEM_WORDS = 1024,
    parameter int QDEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [DBITS-1:0]              req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DBITS-1:0]              rsp_data,
    output logic                          rsp_err,
    input  logic                          ld_en,
    input  logic [$clog2(IMEM_WORDS)-1:0] ld_addr,
    input  logic [DBITS-1:0]              ld_data
);

    localparam int AW = $clog2(IMEM_WORDS);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

    logic              rdy_q;
    logic [QW:0]       occ_q, occ_d;
    logic [QW:0]       cnt_q, cnt_d;
    logic [QW-1:0]     wr_ptr_q, rd_ptr_q;

    logic              s1_v_q, s1_err_q;
    logic [AW-1:0]     s1_idx_q;
    logic              s2_v_q, s2_err_q;
    logic [DBITS-1:0]  s2_data_q;

    logic [DBITS-1:0]  mem_q      [IMEM_WORDS];
    logic [DBITS-1:0]  fifo_data_q [QDEPTH];
    logic              fifo_err_q  [QDEPTH];

    logic              accept, pop, push;
    logic [AW-1:0]     req_idx;
    logic              req_err;

    assign accept = req_valid & req_ready;
    assign pop    = rsp_valid & rsp_ready;
    assign push   = s2_v_q;

    assign req_idx = req_addr[AW+1:2];
    // Misaligned and out-of-range fetches produce the same fault response.
    assign req_err = (req_addr[1:0] != 2'b00)
                   | ((req_addr >> (AW+2)) != '0);

    assign req_ready = rdy_q & (occ_q < QFULL);
    assign rsp_valid = (cnt_q != '0);
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

    always_comb begin
        occ_d = occ_q;
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + (QW+1)'(1);
            2'b01:   occ_d = occ_q - (QW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (QW+1)'(1);
            2'b01:   cnt_d = cnt_q - (QW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rdy_q    <= 1'b0;
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            s1_v_q   <= 1'b0;
            s1_err_q <= 1'b0;
            s1_idx_q <= '0;
            s2_v_q   <= 1'b0;
            s2_err_q <= 1'b0;
        end else begin
            rdy_q    <= 1'b1;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            s1_v_q   <= accept;
            s2_v_q   <= s1_v_q;
            s2_err_q <= s1_err_q;
            if (accept) begin
                s1_idx_q <= req_idx;
                s1_err_q <= req_err;
            end
            if (push) wr_ptr_q <= wr_ptr_q + QW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + QW'(1);
        end
    end

    // Store, read data and FIFO payload are not reset; valids guard them.
    always_ff @(posedge clk) begin
        if (ld_en) mem_q[ld_addr] <= ld_data;
        if (s1_v_q) s2_data_q <= s1_err_q ? '0 : mem_q[s1_idx_q];
        if (push) begin
            fifo_data_q[wr_ptr_q] <= s2_data_q;
            fifo_err_q[wr_ptr_q]  <= s2_err_q;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: fetch, faults, backpressure,
// load collision, mid-run reset and throughput.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        res;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_mem [8];

    always #5 clk = ~clk;

    instr_mem_responder dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] val);
        ld_en   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = val;
        tick();
        ld_en = 1'b0;
        if (idx < 8) exp_mem[idx] = val;
    endtask

    initial begin
        res = 1'b0; req_valid = 1'b0; req_addr = '0;
        rsp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_data", rsp_data, 0);
        tick();
        check("rst_hold_ready", 32'(req_ready), 0);
        #2 res = 1'b1;
        tick();
        check("rel_req_ready", 32'(req_ready), 1);

        for (int k = 0; k < 8; k++) load(k, 32'h1000_0000 + 32'(k));
        load(16, 32'hDEAD_BEEF);

        // single fetch
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        check("one_n0_valid", 32'(rsp_valid), 0);
        tick();
        check("one_n1_valid", 32'(rsp_valid), 0);
        tick();
        check("one_n2_valid", 32'(rsp_valid), 1);
        check("one_n2_data", rsp_data, 32'hDEAD_BEEF);
        check("one_n2_err", 32'(rsp_err), 0);
        tick();
        check("one_n3_valid", 32'(rsp_valid), 0);
        check("one_empty_data", rsp_data, 0);

        // faults
        req_valid = 1'b1; req_addr = 32'h42;
        tick();
        req_addr = 32'h1000;
        tick();
        req_valid = 1'b0;
        tick();
        check("mis_valid", 32'(rsp_valid), 1);
        check("mis_err", 32'(rsp_err), 1);
        check("mis_data", rsp_data, 0);
        tick();
        check("oor_valid", 32'(rsp_valid), 1);
        check("oor_err", 32'(rsp_err), 1);
        check("oor_data", rsp_data, 0);
        tick();
        check("flt_drain", 32'(rsp_valid), 0);

        // backpressure
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 32'(4 * k);
            tick();
        end
        req_addr = 32'h10;
        check("bp_full_ready", 32'(req_ready), 0);
        check("bp_occ", 32'(dut.occ_q), 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_ready", 32'(req_ready), 0);
            check("bp_hold_data", rsp_data, exp_mem[0]);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_pop1_ready", 32'(req_ready), 1);
        check("bp_pop1_data", rsp_data, exp_mem[1]);
        tick();
        req_valid = 1'b0;
        check("bp_acc5_occ", 32'(dut.occ_q), 3);
        check("bp_pop2_data", rsp_data, exp_mem[2]);
        tick();
        check("bp_pop3_data", rsp_data, exp_mem[3]);
        tick();
        check("bp_fifth_valid", 32'(rsp_valid), 1);
        check("bp_fifth_data", rsp_data, exp_mem[4]);
        tick();
        check("bp_drain", 32'(rsp_valid), 0);

        // load collision
        load(3, 32'h11);
        req_valid = 1'b1; req_addr = 32'hC;
        tick();
        req_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 10'd3; ld_data = 32'h22;
        tick();
        ld_en = 1'b0; exp_mem[3] = 32'h22;
        tick();
        check("col_old", rsp_data, 32'h11);
        req_valid = 1'b1; req_addr = 32'hC;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("col_new", rsp_data, 32'h22);
        tick();

        // reset mid-operation
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h40; tick();
        req_addr = 32'h0;  tick();
        req_addr = 32'h4;  tick();
        req_valid = 1'b0;
        check("mr_pre_valid", 32'(rsp_valid), 1);
        #2 res = 1'b0;
        #1;
        check("mr_valid", 32'(rsp_valid), 0);
        check("mr_data", rsp_data, 0);
        check("mr_ready", 32'(req_ready), 0);
        check("mr_occ", 32'(dut.occ_q), 0);
        res = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check("mr_rel_ready", 32'(req_ready), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mr_no_stale", 32'(rsp_valid), 0);
        end
        req_valid = 1'b1; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mr_store_kept", rsp_data, 32'hDEAD_BEEF);
        tick();

        // throughput
        req_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            req_addr = 32'(4 * (k - 1));
            tick();
            check("tp_ready", 32'(req_ready), 1);
            check("tp_occ", 32'(dut.occ_q), (k < 3) ? 32'(k) : 32'd3);
            if (k >= 3) begin
                check("tp_valid", 32'(rsp_valid), 1);
                check("tp_data", rsp_data, exp_mem[k-3]);
            end
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("tp_drain", 32'(rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
